// File: rtl/addr_index_pkg.sv
// Shared constants and error-flag type for the byte-address to word-index pipeline.
package addr_index_pkg;

  localparam int unsigned DEF_BASE  = 16;
  localparam int unsigned DEF_SHIFT = 2;
  localparam int unsigned DEF_DEPTH = 64;

  typedef struct packed {
    logic under;
    logic range;
    logic align;
  } err_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready register slice; accepts whenever empty or draining downstream.
module pipe_stage_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/addr_index_pipe.sv
// Two-stage index = (addr - BASE) >> SHIFT converter with underflow/range flags.
// Define ALIGN_CHECK_EN to carry the low diff bits through S1 and report misalignment.
module addr_index_pipe
  import addr_index_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned BASE   = DEF_BASE,
  parameter int unsigned SHIFT  = DEF_SHIFT,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  index,
  output logic              err_under,
  output logic              err_range,
  output logic              err_align
);

  localparam int unsigned HiW = ADDR_W - SHIFT;
`ifdef ALIGN_CHECK_EN
  localparam int unsigned S1W = HiW + 1 + SHIFT;
`else
  localparam int unsigned S1W = HiW + 1;
`endif
  localparam int unsigned S2W = IDX_W + $bits(err_t);

  logic [ADDR_W:0]  diff;
  logic [S1W-1:0]   s1_in, s1_out;
  logic             s1_valid, s2_ready;
  logic [HiW-1:0]   s1_hi;
  logic             s1_under;
  logic [ADDR_W-1:0] sh;
  err_t             flags_d, flags_q;
  logic [IDX_W-1:0] idx_d;
  logic [S2W-1:0]   s2_in, s2_out;

  // MSB of the widened difference is the borrow, i.e. addr < BASE.
  assign diff = {1'b0, addr} - (ADDR_W+1)'(BASE);

`ifdef ALIGN_CHECK_EN
  assign s1_in = {diff[SHIFT-1:0], diff[ADDR_W], diff[ADDR_W-1:SHIFT]};
`else
  logic unused_lo;
  assign unused_lo = ^diff[SHIFT-1:0];
  assign s1_in     = {diff[ADDR_W], diff[ADDR_W-1:SHIFT]};
`endif

  pipe_stage_reg #(
    .Width (S1W)
  ) u_s1 (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_out)
  );

  assign s1_hi    = s1_out[HiW-1:0];
  assign s1_under = s1_out[HiW];

  // Range check on the full-width shifted value so truncation cannot hide overflow.
  always_comb begin
    sh            = {{SHIFT{1'b0}}, s1_hi};
    flags_d       = '0;
    flags_d.under = s1_under;
    flags_d.range = !s1_under && (sh >= ADDR_W'(DEPTH));
`ifdef ALIGN_CHECK_EN
    flags_d.align = !s1_under && (s1_out[S1W-1 -: SHIFT] != '0);
`else
    flags_d.align = 1'b0;
`endif
    idx_d = (flags_d.under || flags_d.range) ? '0 : sh[IDX_W-1:0];
  end

  assign s2_in = {flags_d, idx_d};

  pipe_stage_reg #(
    .Width (S2W)
  ) u_s2 (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_out)
  );

  assign index     = s2_out[IDX_W-1:0];
  assign flags_q   = err_t'(s2_out[S2W-1:IDX_W]);
  assign err_under = flags_q.under;
  assign err_range = flags_q.range;
  assign err_align = flags_q.align;

endmodule

// File: tb/tb_addr_index_pipe.sv
// Directed self-checking bench for addr_index_pipe (BASE=16, SHIFT=2, DEPTH=64).
module tb_addr_index_pipe;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  index;
  logic        err_under;
  logic        err_range;
  logic        err_align;

  int checks   = 0;
  int failures = 0;

  addr_index_pipe dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr      (addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .index     (index),
    .err_under (err_under),
    .err_range (err_range),
    .err_align (err_align)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; in_valid = 1'b0; addr = '0; out_ready = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, index, err_under, err_range, err_align} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000",
               {out_valid, index, err_under, err_range, err_align});
    end
    Rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; addr = 32'd16; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid);
    end
    addr = 32'd20;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd0 || {err_under, err_range} !== 2'b00) begin
      failures++; $display("FAIL basic_idx0 got v=%b i=%0d e=%b%b exp v=1 i=0 e=00",
                           out_valid, index, err_under, err_range);
    end
    addr = 32'd268;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd1) begin
      failures++; $display("FAIL basic_idx1 got v=%b i=%0d exp v=1 i=1", out_valid, index);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd63 || {err_under, err_range} !== 2'b00) begin
      failures++; $display("FAIL basic_idx63 got v=%b i=%0d e=%b%b exp v=1 i=63 e=00",
                           out_valid, index, err_under, err_range);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL basic_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_errors();
    // addr=12 underflows
    in_valid = 1'b1; addr = 32'd12;
    step();
    addr = 32'd272;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd0 || err_under !== 1'b1 || err_range !== 1'b0) begin
      failures++; $display("FAIL under got v=%b i=%0d u=%b r=%b exp v=1 i=0 u=1 r=0",
                           out_valid, index, err_under, err_range);
    end
    // 0xFFFFFFFF: truncated index would be 0xFB, full-width range check must flag it
    addr = 32'hFFFF_FFFF;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd0 || err_under !== 1'b0 || err_range !== 1'b1) begin
      failures++; $display("FAIL range64 got v=%b i=%0d u=%b r=%b exp v=1 i=0 u=0 r=1",
                           out_valid, index, err_under, err_range);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd0 || err_under !== 1'b0 || err_range !== 1'b1) begin
      failures++; $display("FAIL range_wide got v=%b i=%0d u=%b r=%b exp v=1 i=0 u=0 r=1",
                           out_valid, index, err_under, err_range);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; addr = 32'd36;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_c1 got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    addr = 32'd40;
    step();
    addr = 32'd44;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || index !== 8'd5 || in_ready !== 1'b0 ||
          {err_under, err_range, err_align} !== 3'b000) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b i=%0d rdy=%b e=%b%b%b exp v=1 i=5 rdy=0 e=000",
                 c, out_valid, index, in_ready, err_under, err_range, err_align);
      end
      if (c < 2) step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd6) begin
      failures++; $display("FAIL bp_rel1 got v=%b i=%0d exp v=1 i=6", out_valid, index);
    end
    addr = 32'd48;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd7) begin
      failures++; $display("FAIL bp_rel2 got v=%b i=%0d exp v=1 i=7", out_valid, index);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd8) begin
      failures++; $display("FAIL bp_rel3 got v=%b i=%0d exp v=1 i=8", out_valid, index);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_nodup got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0; in_valid = 1'b1; addr = 32'd36;
    step();
    addr = 32'd40;
    step();
    in_valid = 1'b0;
    Rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || index !== 8'd0) begin
      failures++; $display("FAIL rst_async got v=%b i=%0d exp v=0 i=0", out_valid, index);
    end
    step();
    Rst = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b1; addr = 32'd24;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_stale got=%b exp=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd2) begin
      failures++; $display("FAIL rst_post got v=%b i=%0d exp v=1 i=2", out_valid, index);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_single got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_align();
    logic exp_align;
`ifdef ALIGN_CHECK_EN
    exp_align = 1'b1;
`else
    exp_align = 1'b0;
`endif
    out_ready = 1'b1; in_valid = 1'b1; addr = 32'd17;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || index !== 8'd0 || err_align !== exp_align || err_under !== 1'b0) begin
      failures++; $display("FAIL align17 got v=%b i=%0d a=%b u=%b exp v=1 i=0 a=%b u=0",
                           out_valid, index, err_align, err_under, exp_align);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
